// File: rtl/alu_issue_if.sv
// ID/EX issue-stage bundle: ID-side decode inputs, downstream forwarding
// sources and the registered EX-stage outputs feeding the ALU.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            idValid;
    logic [31:0]     instr;
    logic [XLEN-1:0] rsData;
    logic [XLEN-1:0] rtData;
    logic            stall;
    logic            flush;
    logic            exMemRegWrite;
    logic            memWbRegWrite;
    logic [4:0]      exMemRd;
    logic [4:0]      memWbRd;
    logic [XLEN-1:0] exMemResult;
    logic [XLEN-1:0] memWbResult;
    logic            exValid;
    logic [XLEN-1:0] aluInA;
    logic [XLEN-1:0] aluInB;
    logic [2:0]      aluOp;
    logic [XLEN-1:0] exStoreData;
    logic [4:0]      exRs;
    logic [4:0]      exRt;
    logic [4:0]      exRd;
    logic            exRegWrite;
    logic            exMemRead;
    logic            exMemWrite;
    logic            exBranch;
    logic            exIllegal;

    modport slave (
        input  idValid, instr, rsData, rtData, stall, flush,
        input  exMemRegWrite, memWbRegWrite, exMemRd, memWbRd,
        input  exMemResult, memWbResult,
        output exValid, aluInA, aluInB, aluOp, exStoreData,
        output exRs, exRt, exRd,
        output exRegWrite, exMemRead, exMemWrite, exBranch, exIllegal
    );

    modport master (
        output idValid, instr, rsData, rtData, stall, flush,
        output exMemRegWrite, memWbRegWrite, exMemRd, memWbRd,
        output exMemResult, memWbResult,
        input  exValid, aluInA, aluInB, aluOp, exStoreData,
        input  exRs, exRt, exRd,
        input  exRegWrite, exMemRead, exMemWrite, exBranch, exIllegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS ID/EX issue stage: decode, EX register with stall/flush, and
// optional EX operand forwarding enabled by ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input logic        clk,
    input logic        rst,
    alu_issue_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    typedef struct packed {
        logic            valid;
        logic [2:0]      op;
        logic [XLEN-1:0] rs_val;
        logic [XLEN-1:0] rt_val;
        logic [XLEN-1:0] imm;
        logic            b_imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            illegal;
    } ex_t;

    ex_t dec;
    ex_t ex;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] imm_zx;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign imm_sx = {{(XLEN-16){bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zx = {{(XLEN-16){1'b0}}, bus.instr[15:0]};

    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        dec.rs_val = bus.rsData;
        dec.rt_val = bus.rtData;
        dec.rs     = bus.instr[25:21];
        dec.rt     = bus.instr[20:16];
        dec.imm    = imm_sx;
        case (opcode)
            6'h00: begin
                dec.rd        = bus.instr[15:11];
                dec.reg_write = 1'b1;
                case (funct)
                    6'h20: dec.op = OP_ADD;
                    6'h22: dec.op = OP_SUB;
                    6'h24: dec.op = OP_AND;
                    6'h25: dec.op = OP_OR;
                    6'h2A: dec.op = OP_SLT;
                    default: begin
                        dec.illegal   = 1'b1;
                        dec.reg_write = 1'b0;
                        dec.rd        = 5'd0;
                    end
                endcase
            end
            6'h08: begin
                dec.op        = OP_ADD;
                dec.b_imm     = 1'b1;
                dec.rd        = bus.instr[20:16];
                dec.reg_write = 1'b1;
            end
            6'h0A: begin
                dec.op        = OP_SLT;
                dec.b_imm     = 1'b1;
                dec.rd        = bus.instr[20:16];
                dec.reg_write = 1'b1;
            end
            6'h0C: begin
                dec.op        = OP_AND;
                dec.imm       = imm_zx;
                dec.b_imm     = 1'b1;
                dec.rd        = bus.instr[20:16];
                dec.reg_write = 1'b1;
            end
            6'h0D: begin
                dec.op        = OP_OR;
                dec.imm       = imm_zx;
                dec.b_imm     = 1'b1;
                dec.rd        = bus.instr[20:16];
                dec.reg_write = 1'b1;
            end
            6'h23: begin
                dec.op        = OP_ADD;
                dec.b_imm     = 1'b1;
                dec.rd        = bus.instr[20:16];
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            6'h2B: begin
                dec.op        = OP_ADD;
                dec.b_imm     = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'h04: begin
                dec.op     = OP_SUB;
                dec.branch = 1'b1;
            end
            6'h02: dec.op = OP_ADD;
            default: dec.illegal = 1'b1;
        endcase
        // A write to r0 is architecturally discarded
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ex <= '0;
        end else if (!bus.stall) begin
            ex <= bus.idValid ? dec : '0;
        end
    end

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

`ifdef ALU_ISSUE_FWD_EN
    logic em_ok;
    logic mw_ok;

    assign em_ok = bus.exMemRegWrite && (bus.exMemRd != 5'd0);
    assign mw_ok = bus.memWbRegWrite && (bus.memWbRd != 5'd0);

    // The younger EX/MEM result shadows MEM/WB
    always_comb begin
        fwd_a = ex.rs_val;
        if (em_ok && bus.exMemRd == ex.rs) begin
            fwd_a = bus.exMemResult;
        end else if (mw_ok && bus.memWbRd == ex.rs) begin
            fwd_a = bus.memWbResult;
        end
    end

    always_comb begin
        fwd_b = ex.rt_val;
        if (em_ok && bus.exMemRd == ex.rt) begin
            fwd_b = bus.exMemResult;
        end else if (mw_ok && bus.memWbRd == ex.rt) begin
            fwd_b = bus.memWbResult;
        end
    end
`else
    assign fwd_a = ex.rs_val;
    assign fwd_b = ex.rt_val;
`endif

    assign bus.exValid     = ex.valid;
    assign bus.aluOp       = ex.op;
    assign bus.aluInA      = fwd_a;
    assign bus.aluInB      = ex.b_imm ? ex.imm : fwd_b;
    assign bus.exStoreData = fwd_b;
    assign bus.exRs        = ex.rs;
    assign bus.exRt        = ex.rt;
    assign bus.exRd        = ex.rd;
    assign bus.exRegWrite  = ex.reg_write;
    assign bus.exMemRead   = ex.mem_read;
    assign bus.exMemWrite  = ex.mem_write;
    assign bus.exBranch    = ex.branch;
    assign bus.exIllegal   = ex.illegal;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage for the 5-stage MIPS pipeline: decodes the ID-stage instruction into the 3-bit ALU operation code, operand sources and EX/MEM/WB control, and registers everything into the EX stage. It produces the ALU's `aluInA`, `aluInB` and `aluOp` inputs from the issue side. It also handles stall hold, flush bubbles and, optionally, EX-stage operand forwarding.

## Interface
Parameters:
- `XLEN`, 32, datapath width; `aluInA`/`aluInB`/results are `XLEN` bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `idValid`  in  1  ID stage holds a real instruction.
- `instr`  in  32  ID-stage instruction word.
- `rsData`, `rtData`  in  XLEN  register-file read data for rs/rt.
- `stall`  in  1  hold EX register contents.
- `flush`  in  1  load a bubble into EX.
- `exMemRegWrite`, `memWbRegWrite`  in  1  downstream write enables.
- `exMemRd`, `memWbRd`  in  5  downstream destination registers.
- `exMemResult`, `memWbResult`  in  XLEN  downstream result values.
- `exValid`  out  1  EX holds a real instruction.
- `aluInA`, `aluInB`  out  XLEN  ALU operands.
- `aluOp`  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- `exStoreData`  out  XLEN  store data (rt value) for `sw`.
- `exRs`, `exRt`, `exRd`  out  5  source regs; final destination reg.
- `exRegWrite`, `exMemRead`, `exMemWrite`, `exBranch`, `exIllegal`  out  1 each  control.

## Operation
- Decode, opcode = `instr[31:26]`:
  - Opcode 0x00 (R-type), dest rd, regWrite=1:
    - funct 0x20 → 000.
    - funct 0x22 → 001.
    - funct 0x24 → 010.
    - funct 0x25 → 011.
    - funct 0x2A → 100.
  - 0x08 addi → 000, sign-extended imm, dest rt.
  - 0x0A slti → 100, sign-extended imm, dest rt.
  - 0x0C andi → 010, zero-extended imm, dest rt.
  - 0x0D ori → 011, zero-extended imm, dest rt.
  - 0x23 lw → 000, sign-extended imm, memRead=1, dest rt.
  - 0x2B sw → 000, sign-extended imm, memWrite=1, no regWrite.
  - 0x04 beq → 001, B = rt register, branch=1, no regWrite.
  - 0x02 j → 000, no writes.
  - Anything else, including an unlisted R funct → `exIllegal`=1; all write and memory controls 0; `aluOp`=000.
- `exRegWrite` is forced 0 when the destination is r0.
- Registered per instruction:
  - rs value, rt value, extended immediate.
  - B-select: immediate or register.
  - `exRs`, `exRt`, destination reg.
  - All controls.
- `aluInA` is the rs operand after forwarding.
- `aluInB`:
  - immediate-sourced: the immediate.
  - register-sourced: the rt operand after forwarding.
- `exStoreData` is always the forwarded rt operand.
- `idValid`=0 loads a bubble.
- Bubble contents: `exValid`=0, all controls 0, all data/register fields 0, `aluOp`=000.

## Timing
- Latency: 1 cycle, ID inputs to EX outputs.
- Per-edge priority: `rst` > `flush` > `stall` > load.
  - `rst`: every registered output goes to 0. `aluInA`/`aluInB`/`exStoreData` read 0 unless forwarding matches (it cannot while `exRs`/`exRt`=0).
  - `flush` (including with `stall`): bubble loaded.
  - `stall` alone: all registers hold; forwarding stays live and re-evaluates each cycle.
- Reset asserted mid-stall: reset wins next edge.
- Forwarding is combinational from the registered fields and the downstream inputs (same cycle).
- Forwarding match condition: downstream regWrite=1, rd≠0, rd equals `exRs`/`exRt`.
- EX/MEM has priority over MEM/WB when both match.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding as above.
- Undefined:
  - Forwarding ports remain present but are ignored.
  - `aluInA`, register-sourced `aluInB` and `exStoreData` are the registered `rsData`/`rtData` values.
  - Hazards are then the hazard unit's stall responsibility.

## Test plan
- Reset: `rst`=1 one edge → all outputs 0, `exValid`=0, `aluOp`=000.
- R-type issue: `sub` r3,r1,r2 with rs=10, rt=4 → next cycle `aluOp`=001, A=10, B=4, `exRd`=3, `exRegWrite`=1.
- Immediate extension:
  - `ori` imm 0xFFFF → B=0x0000FFFF, `aluOp`=011.
  - `addi` imm 0xFFFF → B=0xFFFFFFFF.
- Forwarding (macro on): EX holds `add` rs=r5; exMemRd=5/exMemResult=7 and memWbRd=5/memWbResult=9 both writing → A=7. With exMemRegWrite=0 → A=9. With rd=0 → no forward.
- Stall/flush: `stall` 3 cycles → outputs unchanged. `stall`+`flush` together → bubble, `exValid`=0.
- Illegal/r0 cases:
  - Opcode 0x3F → `exIllegal`=1, `exValid`=1, no writes.
  - `add` r0,r1,r2 → `exRegWrite`=0.
